fsab_req_arbiter: RTL and testbench

Two-port request arbiter for the FSAB request channel. It lets two FSAB masters share one FSAB output port: a DMA read controller and a CPU-side or second DMA engine. Arbitration is round-robin at packet granularity, and a write packet is never interleaved with another master's beats. The block owns the downstream credit counter, so the masters see a simple valid/ready handshake instead of credits.

---
 rtl/fsab_req_arbiter.sv | 253 +++++++++++++++++++++++++
 tb/tb_fsab_req_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsab_req_arbiter.sv
// fsab_req_arbiter
// Two-master arbiter for the FSAB request channel. It grants whole packets
// round-robin: a multi-beat write keeps ownership until its last beat. It also
// owns the downstream packet credit counter, so each master sees only a
// valid/ready handshake.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   rqa__fsabo_*             master A beat (valid + mode/did/subdid/addr/len/data/mask)
//   rqa__ready               master A beat accepted this cycle (combinational)
//   rqb__fsabo_*, rqb__ready same for master B
//   arb__fsabo_*             registered downstream beat; valid pulses once per beat
//   arb__fsabo_credit        downstream returns one packet credit (pulse)
//   arb__credit_err          sticky: a credit arrived while the counter was already full
module fsab_req_arbiter #(
  parameter int CREDITS   = 4,
  parameter int MODE_W    = 1,
  parameter int DID_W     = 4,
  parameter int SUBDID_W  = 4,
  parameter int ADDR_W    = 31,
  parameter int LEN_W     = 3,
  parameter int DATA_W    = 64,
  parameter int MASK_W    = 8,
  parameter logic [MODE_W-1:0] FSAB_WRITE = MODE_W'(1)
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                rqa__fsabo_valid,
  input  logic [MODE_W-1:0]   rqa__fsabo_mode,
  input  logic [DID_W-1:0]    rqa__fsabo_did,
  input  logic [SUBDID_W-1:0] rqa__fsabo_subdid,
  input  logic [ADDR_W-1:0]   rqa__fsabo_addr,
  input  logic [LEN_W-1:0]    rqa__fsabo_len,
  input  logic [DATA_W-1:0]   rqa__fsabo_data,
  input  logic [MASK_W-1:0]   rqa__fsabo_mask,
  output logic                rqa__ready,

  input  logic                rqb__fsabo_valid,
  input  logic [MODE_W-1:0]   rqb__fsabo_mode,
  input  logic [DID_W-1:0]    rqb__fsabo_did,
  input  logic [SUBDID_W-1:0] rqb__fsabo_subdid,
  input  logic [ADDR_W-1:0]   rqb__fsabo_addr,
  input  logic [LEN_W-1:0]    rqb__fsabo_len,
  input  logic [DATA_W-1:0]   rqb__fsabo_data,
  input  logic [MASK_W-1:0]   rqb__fsabo_mask,
  output logic                rqb__ready,

  output logic                arb__fsabo_valid,
  output logic [MODE_W-1:0]   arb__fsabo_mode,
  output logic [DID_W-1:0]    arb__fsabo_did,
  output logic [SUBDID_W-1:0] arb__fsabo_subdid,
  output logic [ADDR_W-1:0]   arb__fsabo_addr,
  output logic [LEN_W-1:0]    arb__fsabo_len,
  output logic [DATA_W-1:0]   arb__fsabo_data,
  output logic [MASK_W-1:0]   arb__fsabo_mask,
  input  logic                arb__fsabo_credit,
  output logic                arb__credit_err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;
  localparam logic       OWN_A    = 1'b0;
  localparam logic       OWN_B    = 1'b1;
  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  logic [0:0]       state_r;
  logic             owner_r;
  logic             last_grant_r;
  logic [LEN_W:0]   remaining_r;   // one bit wider than len so len-1 never wraps
  logic [3:0]       credits_r;
  logic             credit_err_r;

  logic             ready_a_s;
  logic             ready_b_s;
  logic             sel_b_s;
  logic             pkt_grant_s;
  logic             beat_accept_s;
  logic             multi_beat_s;

  logic [MODE_W-1:0]   sel_mode_s;
  logic [DID_W-1:0]    sel_did_s;
  logic [SUBDID_W-1:0] sel_subdid_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [LEN_W-1:0]    sel_len_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic [MASK_W-1:0]   sel_mask_s;

  logic                out_valid_r;
  logic [MODE_W-1:0]   out_mode_r;
  logic [DID_W-1:0]    out_did_r;
  logic [SUBDID_W-1:0] out_subdid_r;
  logic [ADDR_W-1:0]   out_addr_r;
  logic [LEN_W-1:0]    out_len_r;
  logic [DATA_W-1:0]   out_data_r;
  logic [MASK_W-1:0]   out_mask_r;

  // Grant decision: packet arbitration in IDLE, owner pass-through in BURST.
  always_comb begin
    ready_a_s   = 1'b0;
    ready_b_s   = 1'b0;
    sel_b_s     = 1'b0;
    pkt_grant_s = 1'b0;
    if (rst) begin
      // ready must never be seen while reset is held, even mid-cycle
      ready_a_s = 1'b0;
      ready_b_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if ((credits_r != 4'd0) && (rqa__fsabo_valid || rqb__fsabo_valid)) begin
            if (rqa__fsabo_valid && rqb__fsabo_valid) begin
              // tie goes to whichever master was not granted last
              sel_b_s = (last_grant_r == OWN_A);
            end else begin
              sel_b_s = rqb__fsabo_valid;
            end
            pkt_grant_s = 1'b1;
            ready_a_s   = ~sel_b_s;
            ready_b_s   = sel_b_s;
          end else begin
            pkt_grant_s = 1'b0;
          end
        end
        ST_BURST: begin
          sel_b_s   = owner_r;
          ready_a_s = (owner_r == OWN_A) && rqa__fsabo_valid;
          ready_b_s = (owner_r == OWN_B) && rqb__fsabo_valid;
        end
        default: begin
          pkt_grant_s = 1'b0;
        end
      endcase
    end
  end

  // Beat field mux towards the output register.
  always_comb begin
    if (sel_b_s) begin
      sel_mode_s   = rqb__fsabo_mode;
      sel_did_s    = rqb__fsabo_did;
      sel_subdid_s = rqb__fsabo_subdid;
      sel_addr_s   = rqb__fsabo_addr;
      sel_len_s    = rqb__fsabo_len;
      sel_data_s   = rqb__fsabo_data;
      sel_mask_s   = rqb__fsabo_mask;
    end else begin
      sel_mode_s   = rqa__fsabo_mode;
      sel_did_s    = rqa__fsabo_did;
      sel_subdid_s = rqa__fsabo_subdid;
      sel_addr_s   = rqa__fsabo_addr;
      sel_len_s    = rqa__fsabo_len;
      sel_data_s   = rqa__fsabo_data;
      sel_mask_s   = rqa__fsabo_mask;
    end
  end

  assign beat_accept_s = ready_a_s | ready_b_s;
  // len 0 and len 1 writes are single-beat packets like reads
  assign multi_beat_s  = (sel_mode_s == FSAB_WRITE) && (sel_len_s > LEN_W'(1));

  // Packet state: IDLE/BURST, burst owner, beats left, round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWN_A;
      last_grant_r <= OWN_B;
      remaining_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pkt_grant_s) begin
            owner_r      <= sel_b_s;
            last_grant_r <= sel_b_s;
            if (multi_beat_s) begin
              state_r     <= ST_BURST;
              remaining_r <= {1'b0, sel_len_s} - (LEN_W+1)'(1);
            end
          end
        end
        ST_BURST: begin
          if (beat_accept_s) begin
            remaining_r <= remaining_r - (LEN_W+1)'(1);
            if (remaining_r == (LEN_W+1)'(1)) begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Downstream credit counter; a returned credit is usable the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_r    <= CRED_MAX;
      credit_err_r <= 1'b0;
    end else begin
      case ({arb__fsabo_credit, pkt_grant_s})
        2'b10: begin
          if (credits_r == CRED_MAX) begin
            credit_err_r <= 1'b1;
          end else begin
            credits_r <= credits_r + 4'd1;
          end
        end
        2'b01:   credits_r <= credits_r - 4'd1;
        default: credits_r <= credits_r;
      endcase
    end
  end

  // Output register: valid pulses per accepted beat, fields hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_mode_r   <= '0;
      out_did_r    <= '0;
      out_subdid_r <= '0;
      out_addr_r   <= '0;
      out_len_r    <= '0;
      out_data_r   <= '0;
      out_mask_r   <= '0;
    end else begin
      out_valid_r <= beat_accept_s;
      if (beat_accept_s) begin
        out_mode_r   <= sel_mode_s;
        out_did_r    <= sel_did_s;
        out_subdid_r <= sel_subdid_s;
        out_addr_r   <= sel_addr_s;
        out_len_r    <= sel_len_s;
        out_data_r   <= sel_data_s;
        out_mask_r   <= sel_mask_s;
      end
    end
  end

  assign rqa__ready        = ready_a_s;
  assign rqb__ready        = ready_b_s;
  assign arb__fsabo_valid  = out_valid_r;
  assign arb__fsabo_mode   = out_mode_r;
  assign arb__fsabo_did    = out_did_r;
  assign arb__fsabo_subdid = out_subdid_r;
  assign arb__fsabo_addr   = out_addr_r;
  assign arb__fsabo_len    = out_len_r;
  assign arb__fsabo_data   = out_data_r;
  assign arb__fsabo_mask   = out_mask_r;
  assign arb__credit_err   = credit_err_r;

endmodule

// File: tb/tb_fsab_req_arbiter.sv
// Self-checking bench for fsab_req_arbiter: directed scenarios plus randomized
// traffic, checked cycle by cycle against a packet-level reference model.
module tb_fsab_req_arbiter;

  localparam int CREDITS = 4;
  localparam logic [0:0] WR = 1'b1;

  typedef struct packed {
    logic [0:0]  mode;
    logic [3:0]  did;
    logic [3:0]  subdid;
    logic [30:0] addr;
    logic [2:0]  len;
    logic [63:0] data;
    logic [7:0]  mask;
  } beat_t;

  typedef struct {
    beat_t b;
    bit    first;
  } ent_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  val_a, val_b, credit;
  beat_t beat_a, beat_b;
  logic  rqa__ready, rqb__ready;
  logic  arb__fsabo_valid, arb__credit_err;
  logic [0:0]  o_mode;
  logic [3:0]  o_did, o_subdid;
  logic [30:0] o_addr;
  logic [2:0]  o_len;
  logic [63:0] o_data;
  logic [7:0]  o_mask;
  beat_t out_b;

  assign out_b = {o_mode, o_did, o_subdid, o_addr, o_len, o_data, o_mask};

  fsab_req_arbiter #(.CREDITS(CREDITS)) dut (
    .clk(clk), .rst(rst),
    .rqa__fsabo_valid(val_a), .rqa__fsabo_mode(beat_a.mode), .rqa__fsabo_did(beat_a.did),
    .rqa__fsabo_subdid(beat_a.subdid), .rqa__fsabo_addr(beat_a.addr), .rqa__fsabo_len(beat_a.len),
    .rqa__fsabo_data(beat_a.data), .rqa__fsabo_mask(beat_a.mask), .rqa__ready(rqa__ready),
    .rqb__fsabo_valid(val_b), .rqb__fsabo_mode(beat_b.mode), .rqb__fsabo_did(beat_b.did),
    .rqb__fsabo_subdid(beat_b.subdid), .rqb__fsabo_addr(beat_b.addr), .rqb__fsabo_len(beat_b.len),
    .rqb__fsabo_data(beat_b.data), .rqb__fsabo_mask(beat_b.mask), .rqb__ready(rqb__ready),
    .arb__fsabo_valid(arb__fsabo_valid), .arb__fsabo_mode(o_mode), .arb__fsabo_did(o_did),
    .arb__fsabo_subdid(o_subdid), .arb__fsabo_addr(o_addr), .arb__fsabo_len(o_len),
    .arb__fsabo_data(o_data), .arb__fsabo_mask(o_mask), .arb__fsabo_credit(credit),
    .arb__credit_err(arb__credit_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int gap = 0;
  ent_t qa[$];
  ent_t qb[$];
  bit got_ra, got_rb, acc_a, acc_b;

  // reference model state (packet level, plain integers)
  int    m_cred, m_left, m_owner, m_last;
  bit    m_err, m_cin;
  bit    exp_ra, exp_rb, exp_ov;
  beat_t exp_ob;

  task automatic model_reset();
    m_cred = CREDITS; m_left = 0; m_owner = 0; m_last = 1; m_err = 1'b0;
    exp_ov = 1'b0; exp_ob = '0; exp_ra = 1'b0; exp_rb = 1'b0;
  endtask

  // who should be handed ready given the current inputs
  task automatic model_comb();
    exp_ra = 1'b0; exp_rb = 1'b0;
    m_cin = credit;
    if (!rst) begin
      if (m_left > 0) begin
        if (m_owner == 0) exp_ra = val_a; else exp_rb = val_b;
      end else if (m_cred > 0) begin
        if (val_a && val_b) begin
          if (m_last == 1) exp_ra = 1'b1; else exp_rb = 1'b1;
        end else begin
          exp_ra = val_a; exp_rb = val_b;
        end
      end
    end
  endtask

  // consequences of the clock edge
  task automatic model_seq();
    int    who;
    bit    grant;
    int    nbeats;
    beat_t b;
    if (rst) begin
      model_reset();
    end else begin
      who = exp_ra ? 0 : (exp_rb ? 1 : -1);
      grant = 1'b0;
      exp_ov = (who >= 0);
      if (who >= 0) begin
        b = (who == 0) ? beat_a : beat_b;
        exp_ob = b;
        if (m_left > 0) begin
          m_left = m_left - 1;
        end else begin
          grant = 1'b1;
          m_last = who; m_owner = who;
          nbeats = (b.mode == WR) ? ((b.len == 3'd0) ? 1 : int'(b.len)) : 1;
          m_left = nbeats - 1;
        end
      end
      if (grant && !m_cin) m_cred = m_cred - 1;
      else if (!grant && m_cin) begin
        if (m_cred == CREDITS) m_err = 1'b1; else m_cred = m_cred + 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_comb();
    got_ra = rqa__ready; got_rb = rqb__ready;
    acc_a = got_ra & val_a; acc_b = got_rb & val_b;
    @(posedge clk); #1;
    model_seq();
    cyc++;
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b.mode = 1'($urandom); b.did = 4'($urandom); b.subdid = 4'($urandom);
    b.addr = 31'($urandom); b.len = 3'($urandom);
    b.data = {$urandom, $urandom}; b.mask = 8'($urandom);
    return b;
  endfunction

  task automatic push_pkt(input int m, input bit wr, input int len, input int did);
    ent_t  e;
    beat_t hdr;
    int    n;
    hdr = rand_beat();
    hdr.mode = wr ? WR : ~WR;
    hdr.len = 3'(len);
    if (did >= 0) hdr.did = 4'(did);
    n = (wr && len > 1) ? len : 1;
    for (int i = 0; i < n; i++) begin
      e.b = hdr; e.b.data = {$urandom, $urandom}; e.b.mask = 8'($urandom);
      e.first = (i == 0);
      if (m == 0) qa.push_back(e); else qb.push_back(e);
    end
  endtask

  // master behaviour: hold a beat until ready, drop valid only between packets
  task automatic drive_one(input int m);
    ent_t  e;
    bit    have, acc;
    logic  v;
    beat_t b;
    if (m == 0) begin acc = acc_a; v = val_a; b = beat_a; end
    else begin acc = acc_b; v = val_b; b = beat_b; end
    if (acc) begin
      if (m == 0) void'(qa.pop_front()); else void'(qb.pop_front());
      v = 1'b0;
    end
    have = (m == 0) ? (qa.size() > 0) : (qb.size() > 0);
    if (have) e = (m == 0) ? qa[0] : qb[0];
    if (!v) begin
      if (have && (!e.first || $urandom_range(99) >= gap)) begin v = 1'b1; b = e.b; end
      else begin v = 1'b0; b = rand_beat(); end
    end
    if (m == 0) begin val_a = v; beat_a = b; end
    else begin val_b = v; beat_b = b; end
  endtask

  task automatic drive();
    drive_one(0);
    drive_one(1);
  endtask

  task automatic do_reset();
    rst = 1'b1; model_reset();
    qa.delete(); qb.delete();
    val_a = 1'b0; val_b = 1'b0; credit = 1'b0; acc_a = 1'b0; acc_b = 1'b0; gap = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; model_reset();
    val_a = 1'b1; val_b = 1'b1; beat_a = rand_beat(); beat_b = rand_beat(); credit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({got_ra, got_rb} !== {exp_ra, exp_rb}) begin
        n_fail++; $display("FAIL reset_ready cyc %0d: got %b%b want %b%b", cyc, got_ra, got_rb, exp_ra, exp_rb);
      end
      n_cmp++;
      if ({arb__fsabo_valid, out_b, arb__credit_err} !== {exp_ov, exp_ob, m_err}) begin
        n_fail++; $display("FAIL reset_out cyc %0d: got v=%b %h err=%b want v=%b %h err=%b",
                           cyc, arb__fsabo_valid, out_b, arb__credit_err, exp_ov, exp_ob, m_err);
      end
    end
    val_a = 1'b0; val_b = 1'b0; acc_a = 1'b0; acc_b = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_three_reads();
    int nout = 0;
    for (int i = 0; i < 3; i++) push_pkt(0, 1'b0, 1, -1);
    for (int i = 0; i < 7; i++) begin
      drive(); tick();
      if (arb__fsabo_valid) nout++;
      n_cmp++;
      if ({got_ra, got_rb} !== {exp_ra, exp_rb}) begin
        n_fail++; $display("FAIL reads_ready cyc %0d: got %b%b want %b%b", cyc, got_ra, got_rb, exp_ra, exp_rb);
      end
      n_cmp++;
      if ({arb__fsabo_valid, out_b, arb__credit_err} !== {exp_ov, exp_ob, m_err}) begin
        n_fail++; $display("FAIL reads_out cyc %0d: got v=%b %h err=%b want v=%b %h err=%b",
                           cyc, arb__fsabo_valid, out_b, arb__credit_err, exp_ov, exp_ob, m_err);
      end
    end
    n_cmp++;
    if (nout !== 3) begin n_fail++; $display("FAIL reads_count: got %0d want 3", nout); end
  endtask

  task automatic test_alternate();
    bit prev_b = 1'b0;
    for (int i = 0; i < 6; i++) begin push_pkt(0, 1'b0, 1, 1); push_pkt(1, 1'b0, 1, 2); end
    for (int i = 0; i < 12; i++) begin
      drive(); credit = 1'b1; tick();
      n_cmp++;
      if ((got_ra ^ got_rb) !== 1'b1 || (i > 0 && got_rb == prev_b)) begin
        n_fail++; $display("FAIL alt_order cyc %0d: got ra=%b rb=%b prev_b=%b want alternating", cyc, got_ra, got_rb, prev_b);
      end
      prev_b = got_rb;
      n_cmp++;
      if ({arb__fsabo_valid, out_b, arb__credit_err} !== {exp_ov, exp_ob, m_err}) begin
        n_fail++; $display("FAIL alt_out cyc %0d: got v=%b %h err=%b want v=%b %h err=%b",
                           cyc, arb__fsabo_valid, out_b, arb__credit_err, exp_ov, exp_ob, m_err);
      end
    end
    credit = 1'b0;
    drive(); tick();
  endtask

  task automatic test_burst_block();
    logic [19:0] seq = '0;
    int nout = 0;
    do_reset();
    push_pkt(0, 1'b1, 4, 3);
    push_pkt(1, 1'b0, 1, 5);
    for (int i = 0; i < 8; i++) begin
      drive(); tick();
      if (arb__fsabo_valid) begin seq = {seq[15:0], o_did}; nout++; end
      n_cmp++;
      if ({got_ra, got_rb} !== {exp_ra, exp_rb}) begin
        n_fail++; $display("FAIL burst_ready cyc %0d: got %b%b want %b%b", cyc, got_ra, got_rb, exp_ra, exp_rb);
      end
      n_cmp++;
      if ({arb__fsabo_valid, out_b, arb__credit_err} !== {exp_ov, exp_ob, m_err}) begin
        n_fail++; $display("FAIL burst_out cyc %0d: got v=%b %h err=%b want v=%b %h err=%b",
                           cyc, arb__fsabo_valid, out_b, arb__credit_err, exp_ov, exp_ob, m_err);
      end
    end
    n_cmp++;
    if (nout !== 5 || seq !== 20'h33335) begin
      n_fail++; $display("FAIL burst_seq: got n=%0d dids=%h want n=5 dids=33335", nout, seq);
    end
  endtask

  task automatic test_credit_exhaust();
    int nout = 0;
    do_reset();
    for (int i = 0; i < 5; i++) push_pkt(0, 1'b0, 1, -1);
    for (int i = 0; i < 12; i++) begin
      drive(); credit = (i == 8); tick();
      if (arb__fsabo_valid) nout++;
      if (i == 8) begin
        n_cmp++;
        if (nout !== 4) begin n_fail++; $display("FAIL exhaust_stall: got %0d beats want 4", nout); end
      end
      n_cmp++;
      if ({got_ra, got_rb} !== {exp_ra, exp_rb}) begin
        n_fail++; $display("FAIL exhaust_ready cyc %0d: got %b%b want %b%b", cyc, got_ra, got_rb, exp_ra, exp_rb);
      end
      n_cmp++;
      if ({arb__fsabo_valid, out_b, arb__credit_err} !== {exp_ov, exp_ob, m_err}) begin
        n_fail++; $display("FAIL exhaust_out cyc %0d: got v=%b %h err=%b want v=%b %h err=%b",
                           cyc, arb__fsabo_valid, out_b, arb__credit_err, exp_ov, exp_ob, m_err);
      end
    end
    credit = 1'b0;
    n_cmp++;
    if (nout !== 5) begin n_fail++; $display("FAIL exhaust_resume: got %0d beats want 5", nout); end
  endtask

  task automatic test_credit_overflow();
    int nout = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i == 4) for (int k = 0; k < 5; k++) push_pkt(1, 1'b0, 1, -1);
      drive(); credit = (i == 0); tick();
      if (arb__fsabo_valid) nout++;
      n_cmp++;
      if (arb__credit_err !== 1'b1) begin
        n_fail++; $display("FAIL overflow_err cyc %0d: got %b want 1", cyc, arb__credit_err);
      end
      n_cmp++;
      if ({got_ra, got_rb} !== {exp_ra, exp_rb}) begin
        n_fail++; $display("FAIL overflow_ready cyc %0d: got %b%b want %b%b", cyc, got_ra, got_rb, exp_ra, exp_rb);
      end
    end
    credit = 1'b0;
    n_cmp++;
    if (nout !== 4) begin n_fail++; $display("FAIL overflow_sat: got %0d beats want 4", nout); end
  endtask

  task automatic test_reset_mid_burst();
    int nout = 0;
    do_reset();
    push_pkt(0, 1'b1, 4, -1);
    drive(); tick();
    n_cmp++;
    if ({got_ra, got_rb, arb__fsabo_valid} !== 3'b101) begin
      n_fail++; $display("FAIL midrst_first: got ra=%b rb=%b v=%b want 1 0 1", got_ra, got_rb, arb__fsabo_valid);
    end
    drive();
    rst = 1'b1; model_reset();
    #1;
    n_cmp++;
    if ({arb__fsabo_valid, out_b, rqa__ready, rqb__ready} !== '0) begin
      n_fail++; $display("FAIL midrst_clear: got v=%b %h ra=%b rb=%b want all 0", arb__fsabo_valid, out_b, rqa__ready, rqb__ready);
    end
    qa.delete(); qb.delete(); acc_a = 1'b0; acc_b = 1'b0;
    tick(); tick();
    rst = 1'b0; val_a = 1'b0; val_b = 1'b0;
    for (int k = 0; k < 5; k++) push_pkt(1, 1'b0, 1, -1);
    for (int i = 0; i < 8; i++) begin
      drive(); tick();
      if (arb__fsabo_valid) nout++;
      if (i == 0) begin
        n_cmp++;
        if ({got_ra, got_rb} !== 2'b01) begin
          n_fail++; $display("FAIL midrst_bfirst: got %b%b want 01", got_ra, got_rb);
        end
      end
      n_cmp++;
      if ({arb__fsabo_valid, out_b, arb__credit_err} !== {exp_ov, exp_ob, m_err}) begin
        n_fail++; $display("FAIL midrst_out cyc %0d: got v=%b %h err=%b want v=%b %h err=%b",
                           cyc, arb__fsabo_valid, out_b, arb__credit_err, exp_ov, exp_ob, m_err);
      end
    end
    n_cmp++;
    if (nout !== 4) begin n_fail++; $display("FAIL midrst_credits: got %0d beats want 4", nout); end
  endtask

  task automatic test_random();
    do_reset();
    gap = 30;
    for (int i = 0; i < 400; i++) begin
      if (qa.size() < 3 && $urandom_range(1) == 1) push_pkt(0, 1'($urandom), int'($urandom_range(7)), -1);
      if (qb.size() < 3 && $urandom_range(1) == 1) push_pkt(1, 1'($urandom), int'($urandom_range(7)), -1);
      drive();
      credit = (m_cred < CREDITS) && ($urandom_range(1) == 1);
      tick();
      n_cmp++;
      if ({got_ra, got_rb} !== {exp_ra, exp_rb} || (got_ra && got_rb)) begin
        n_fail++; $display("FAIL rand_ready cyc %0d: got %b%b want %b%b", cyc, got_ra, got_rb, exp_ra, exp_rb);
      end
      n_cmp++;
      if ({arb__fsabo_valid, out_b, arb__credit_err} !== {exp_ov, exp_ob, m_err}) begin
        n_fail++; $display("FAIL rand_out cyc %0d: got v=%b %h err=%b want v=%b %h err=%b",
                           cyc, arb__fsabo_valid, out_b, arb__credit_err, exp_ov, exp_ob, m_err);
      end
    end
    credit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; val_a = 1'b0; val_b = 1'b0; credit = 1'b0;
    beat_a = '0; beat_b = '0; acc_a = 1'b0; acc_b = 1'b0;
    model_reset();
    test_reset();
    test_three_reads();
    test_alternate();
    test_burst_block();
    test_credit_exhaust();
    test_credit_overflow();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
